// File: rtl/insn_encoder.sv
// rtl/insn_encoder.sv - streaming RV32IM instruction encoder with LI expansion and imm range checks
// Optional feature macro: ENC_M_EXT_EN (adds MUL/DIV/REM encodings for ops 0x25-0x2C)
module insn_encoder #(
  parameter int CHECK_IMM = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_op,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_insn,
  output logic                 out_last,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  typedef enum logic [3:0] {F_BAD, F_U, F_J, F_I, F_B, F_S, F_SH, F_R, F_LI} fmt_t;
  typedef enum logic {IDLE, PEND2} state_t;

  state_t      state;
  fmt_t        fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        fits12, fits13, fits21, imm_ok, bad, need2;
  logic [31:0] li_sum, w0, w1, word1_q;
  logic        advance, accept;

  // Map operation id to instruction format and fixed opcode/funct fields
  always_comb begin
    fmt = F_BAD;
    opc = 7'd0;
    f3  = 3'd0;
    f7  = 7'd0;
    case (in_op)
      6'h00: begin fmt = F_U;  opc = OPC_LUI;   end
      6'h01: begin fmt = F_U;  opc = OPC_AUIPC; end
      6'h02: begin fmt = F_J;  opc = OPC_JAL;   end
      6'h03: begin fmt = F_I;  opc = OPC_JALR;  end
      6'h04: begin fmt = F_B;  opc = OPC_BR;  f3 = 3'd0; end
      6'h05: begin fmt = F_B;  opc = OPC_BR;  f3 = 3'd1; end
      6'h06: begin fmt = F_B;  opc = OPC_BR;  f3 = 3'd4; end
      6'h07: begin fmt = F_B;  opc = OPC_BR;  f3 = 3'd5; end
      6'h08: begin fmt = F_B;  opc = OPC_BR;  f3 = 3'd6; end
      6'h09: begin fmt = F_B;  opc = OPC_BR;  f3 = 3'd7; end
      6'h0A: begin fmt = F_I;  opc = OPC_LD;  f3 = 3'd0; end
      6'h0B: begin fmt = F_I;  opc = OPC_LD;  f3 = 3'd1; end
      6'h0C: begin fmt = F_I;  opc = OPC_LD;  f3 = 3'd2; end
      6'h0D: begin fmt = F_I;  opc = OPC_LD;  f3 = 3'd4; end
      6'h0E: begin fmt = F_I;  opc = OPC_LD;  f3 = 3'd5; end
      6'h0F: begin fmt = F_S;  opc = OPC_ST;  f3 = 3'd0; end
      6'h10: begin fmt = F_S;  opc = OPC_ST;  f3 = 3'd1; end
      6'h11: begin fmt = F_S;  opc = OPC_ST;  f3 = 3'd2; end
      6'h12: begin fmt = F_I;  opc = OPC_IMM; f3 = 3'd0; end
      6'h13: begin fmt = F_I;  opc = OPC_IMM; f3 = 3'd2; end
      6'h14: begin fmt = F_I;  opc = OPC_IMM; f3 = 3'd3; end
      6'h15: begin fmt = F_I;  opc = OPC_IMM; f3 = 3'd4; end
      6'h16: begin fmt = F_I;  opc = OPC_IMM; f3 = 3'd6; end
      6'h17: begin fmt = F_I;  opc = OPC_IMM; f3 = 3'd7; end
      6'h18: begin fmt = F_SH; opc = OPC_IMM; f3 = 3'd1; end
      6'h19: begin fmt = F_SH; opc = OPC_IMM; f3 = 3'd5; end
      6'h1A: begin fmt = F_SH; opc = OPC_IMM; f3 = 3'd5; f7 = 7'h20; end
      6'h1B: begin fmt = F_R;  opc = OPC_OP;  f3 = 3'd0; end
      6'h1C: begin fmt = F_R;  opc = OPC_OP;  f3 = 3'd0; f7 = 7'h20; end
      6'h1D: begin fmt = F_R;  opc = OPC_OP;  f3 = 3'd1; end
      6'h1E: begin fmt = F_R;  opc = OPC_OP;  f3 = 3'd2; end
      6'h1F: begin fmt = F_R;  opc = OPC_OP;  f3 = 3'd3; end
      6'h20: begin fmt = F_R;  opc = OPC_OP;  f3 = 3'd4; end
      6'h21: begin fmt = F_R;  opc = OPC_OP;  f3 = 3'd5; end
      6'h22: begin fmt = F_R;  opc = OPC_OP;  f3 = 3'd5; f7 = 7'h20; end
      6'h23: begin fmt = F_R;  opc = OPC_OP;  f3 = 3'd6; end
      6'h24: begin fmt = F_R;  opc = OPC_OP;  f3 = 3'd7; end
`ifdef ENC_M_EXT_EN
      6'h25, 6'h26, 6'h27, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C: begin
        fmt = F_R;
        opc = OPC_OP;
        f3  = 3'(in_op - 6'h25);
        f7  = 7'h01;
      end
`endif
      6'h2D: fmt = F_LI;
      default: fmt = F_BAD;
    endcase
  end

  // Immediate range check for the selected format
  always_comb begin
    fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    case (fmt)
      F_U:      imm_ok = ~(|in_imm[11:0]);
      F_J:      imm_ok = fits21 & ~in_imm[0];
      F_I, F_S: imm_ok = fits12;
      F_B:      imm_ok = fits13 & ~in_imm[0];
      F_SH:     imm_ok = ~(|in_imm[31:5]);
      default:  imm_ok = 1'b1;
    endcase
    bad = (fmt == F_BAD) || ((CHECK_IMM != 0) && !imm_ok);
  end

  // Build the first word and, for a split LI, the trailing ADDI
  always_comb begin
    li_sum = in_imm + 32'h0000_0800;
    w1     = {in_imm[11:0], in_rd, 3'b000, in_rd, OPC_IMM};
    need2  = 1'b0;
    case (fmt)
      F_U:  w0 = {in_imm[31:12], in_rd, opc};
      F_J:  w0 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
      F_I:  w0 = {in_imm[11:0], in_rs1, f3, in_rd, opc};
      F_B:  w0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
      F_S:  w0 = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
      F_SH: w0 = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
      F_R:  w0 = {f7, in_rs2, in_rs1, f3, in_rd, opc};
      F_LI: begin
        if (fits12) begin
          w0 = {in_imm[11:0], 5'd0, 3'b000, in_rd, OPC_IMM};
        end else begin
          w0    = {li_sum[31:12], in_rd, OPC_LUI};
          need2 = |in_imm[11:0];
        end
      end
      default: w0 = 32'd0;
    endcase
  end

  assign advance  = !out_valid || out_ready;
  assign in_ready = (state == IDLE) && advance;
  assign accept   = in_valid && in_ready;

  // Output register, LI expansion FSM and error pulse/counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_insn  <= 32'd0;
      out_last  <= 1'b0;
      word1_q   <= 32'd0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= 1'b0;
      if (advance) begin
        if (state == PEND2) begin
          out_insn  <= word1_q;
          out_last  <= 1'b1;
          out_valid <= 1'b1;
          state     <= IDLE;
        end else if (accept) begin
          if (bad) begin
            out_valid <= 1'b0;
            err       <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
          end else begin
            out_insn  <= w0;
            out_last  <= !need2;
            out_valid <= 1'b1;
            word1_q   <= w1;
            if (need2) state <= PEND2;
          end
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
